ct_mmu_dutlb_refill_ctrl: RTL and testbench
===========================================

# ct_mmu_dutlb_refill_ctrl

Refill controller for the data micro-TLB. It arbitrates miss requests from the two LSU lookup ports and sequences one jTLB lookup at a time. It then writes the returned translation into either a normal uTLB entry, chosen by round-robin, or the single huge (1G) entry. It sits between the LSU uTLB lookup stage, the jTLB request interface and the uTLB entry array, and it aborts cleanly when a TLB-maintenance clear is requested.

## Interface
- VPN_WIDTH, 27, virtual page number width
- PPN_WIDTH, 28, physical page number width
- FLG_WIDTH, 14, PTE flag width
- PGS_WIDTH, 3, page-size code width
- ENTRY_NUM, 8, normal uTLB entries (power of two)

Ports:
- utlb_clk  in  1  clock
- cpurst  in  1  reset, asynchronous, active-high
- lsu_utlb_miss0 / lsu_utlb_miss1  in  1  port miss, held high until matching done pulse
- lsu_utlb_vpn0 / lsu_utlb_vpn1  in  VPN_WIDTH  miss VPN, stable while miss high
- utlb_jtlb_req  out  1  jTLB lookup request
- utlb_jtlb_vpn  out  VPN_WIDTH  request VPN
- jtlb_utlb_grnt  in  1  request accepted
- jtlb_utlb_resp  in  1  response valid (one cycle)
- jtlb_utlb_fault  in  1  page fault, qualified by resp
- jtlb_utlb_pgs  in  PGS_WIDTH  page size: 001 4K, 010 2M, 100 1G
- jtlb_utlb_ppn  in  PPN_WIDTH; jtlb_utlb_flg  in  FLG_WIDTH
- tlboper_utlb_clr  in  1  uTLB flush (abort)
- utlb_entry_upd  out  ENTRY_NUM  one-hot normal-entry write
- utlb_huge_upd  out  1  huge-entry write
- utlb_upd_vpn / utlb_upd_ppn / utlb_upd_flg  out  widths as above  write data
- utlb_refill_done0 / utlb_refill_done1  out  1  per-port completion pulse
- utlb_refill_fault  out  1  completion carries fault
- utlb_refill_busy  out  1  FSM not IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN, UPD.
- IDLE: if any miss, select a port by the round-robin arbiter and latch its port index and VPN. Go to REQ.
- REQ: drive utlb_jtlb_req and utlb_jtlb_vpn. On grnt go to WAIT. On clr go to IDLE, no grnt needed, and pulse done for the latched port with no update.
- WAIT: on resp, latch pgs/ppn/flg/fault and go to UPD. On clr without resp go to DRAIN. On clr and resp in the same cycle, discard the response and go to IDLE with a done pulse.
- DRAIN: wait for resp, discard it, pulse done with no update, go to IDLE.
- UPD (one cycle): if fault, no write; pulse done and fault. Otherwise, if pgs==100, write the huge entry; else write the normal entry at the round-robin pointer and increment the pointer. Pulse done. Return to IDLE.
- clr during UPD: suppress all writes, still pulse done, do not advance the pointer.
- Arbiter: if both ports miss, the port not served last wins. A single miss wins immediately. The last-served bit resets to port1, so port0 wins first.
- Merge: at completion, if the other port's miss is high with an identical VPN, pulse both dones in the same cycle, with fault applied to both.
- Pointer: log2(ENTRY_NUM) bits, wraps ENTRY_NUM-1 to 0.
- Write-data outputs are driven only in UPD and are zero otherwise.

## Timing
- Reset values: all outputs 0, FSM IDLE, pointer 0.
- Miss sampled in IDLE at cycle N produces req high at cycle N+1.
- resp at cycle M produces upd and done at cycle M+1.
- Minimum miss-to-done latency is 3 cycles (grnt at N+1, resp at N+2).
- The earliest next arbitration is the cycle after UPD.
- req stays high until grnt or clr. VPN is stable while req is high.
- Reset mid-operation returns to IDLE immediately with no done pulse. The LSU re-presents the miss after reset.

## Structure
- ct_mmu_utlb_pkg holds the width constants, page-size encodings (PGS_4K/2M/1G), and the refill state enum.
- Sub-module ct_mmu_utlb_rr_arb is the 2-way round-robin arbiter holding the last-served flop.

## Test plan
- Port0 miss, VPN 0x0012345; grnt at +1, resp at +2 with pgs 001 and ppn 0xABCDE -> utlb_entry_upd=0x01 and done0 at +3; next refill writes 0x02.
- Both ports miss with different VPNs -> port0 served first, then port1; arbitration alternates over four back-to-back double misses.
- Both miss on the same VPN -> one jTLB req; done0 and done1 in the same cycle.
- resp with pgs 100 -> utlb_huge_upd=1, utlb_entry_upd=0, pointer unchanged; resp with fault=1 -> no write, done and fault pulse.
- clr in REQ, clr in WAIT (DRAIN, then late resp), and clr coinciding with resp -> no write in every case, exactly one done pulse each, req drops the cycle after clr.
- Nine normal refills -> pointer wraps and the ninth writes entry 0; assert cpurst mid-WAIT -> all outputs 0 and IDLE.

Source files
------------

// File: rtl/ct_mmu_utlb_pkg.sv
// Shared constants and types for the data uTLB refill controller.
// Widths, page-size encodings and the refill FSM state encoding live here.
package ct_mmu_utlb_pkg;

  localparam int VPN_WIDTH = 27;
  localparam int PPN_WIDTH = 28;
  localparam int FLG_WIDTH = 14;
  localparam int PGS_WIDTH = 3;
  localparam int ENTRY_NUM = 8;
  localparam int PTR_WIDTH = $clog2(ENTRY_NUM);

  localparam logic [PGS_WIDTH-1:0] PGS_4K = 3'b001;
  localparam logic [PGS_WIDTH-1:0] PGS_2M = 3'b010;
  localparam logic [PGS_WIDTH-1:0] PGS_1G = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_UPD   = 3'd4
  } refill_state_e;

endpackage

// File: rtl/ct_mmu_utlb_rr_arb.sv
// Two-way round-robin arbiter for the LSU miss ports.
// The last-served flop resets to port1 so port0 wins the first contention.
module ct_mmu_utlb_rr_arb
  import ct_mmu_utlb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic accept,
  output logic gnt_valid,
  output logic gnt_port
);

  logic last_port;

  always_comb begin
    gnt_valid = req0 | req1;
    if (req0 && req1) gnt_port = ~last_port;
    else              gnt_port = req1;
  end

  // NOTE: sequential state always uses non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      last_port <= 1'b1;
    else if (accept && gnt_valid) last_port <= gnt_port;
  end

endmodule

// File: rtl/ct_mmu_dutlb_refill_ctrl.sv
// Data uTLB refill controller: arbitrates LSU misses, runs one jTLB lookup at
// a time and writes the result into a round-robin normal entry or the huge entry.
module ct_mmu_dutlb_refill_ctrl
  import ct_mmu_utlb_pkg::*;
(
  input  logic                 utlb_clk,
  input  logic                 cpurst,
  input  logic                 lsu_utlb_miss0,
  input  logic                 lsu_utlb_miss1,
  input  logic [VPN_WIDTH-1:0] lsu_utlb_vpn0,
  input  logic [VPN_WIDTH-1:0] lsu_utlb_vpn1,
  output logic                 utlb_jtlb_req,
  output logic [VPN_WIDTH-1:0] utlb_jtlb_vpn,
  input  logic                 jtlb_utlb_grnt,
  input  logic                 jtlb_utlb_resp,
  input  logic                 jtlb_utlb_fault,
  input  logic [PGS_WIDTH-1:0] jtlb_utlb_pgs,
  input  logic [PPN_WIDTH-1:0] jtlb_utlb_ppn,
  input  logic [FLG_WIDTH-1:0] jtlb_utlb_flg,
  input  logic                 tlboper_utlb_clr,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic                 utlb_huge_upd,
  output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
  output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
  output logic [FLG_WIDTH-1:0] utlb_upd_flg,
  output logic                 utlb_refill_done0,
  output logic                 utlb_refill_done1,
  output logic                 utlb_refill_fault,
  output logic                 utlb_refill_busy
);

  refill_state_e state, state_nxt;

  logic                 port_q;
  logic [VPN_WIDTH-1:0] vpn_q;
  logic [PGS_WIDTH-1:0] pgs_q;
  logic [PPN_WIDTH-1:0] ppn_q;
  logic [FLG_WIDTH-1:0] flg_q;
  logic                 fault_q;
  logic [PTR_WIDTH-1:0] ptr_q;

  logic gnt_valid;
  logic gnt_port;
  logic arb_accept;
  logic complete;
  logic upd_ok;
  logic wr_huge;
  logic wr_normal;
  logic merge;

  assign arb_accept = (state == ST_IDLE);

  ct_mmu_utlb_rr_arb u_arb (
    .clk       (utlb_clk),
    .rst       (cpurst),
    .req0      (lsu_utlb_miss0),
    .req1      (lsu_utlb_miss1),
    .accept    (arb_accept),
    .gnt_valid (gnt_valid),
    .gnt_port  (gnt_port)
  );

  always_ff @(posedge utlb_clk or posedge cpurst) begin
    if (cpurst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt_valid) state_nxt = ST_REQ;
      ST_REQ: begin
        if (tlboper_utlb_clr)    state_nxt = ST_IDLE;
        else if (jtlb_utlb_grnt) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving with the flush is dropped; without it we must drain.
        if (tlboper_utlb_clr)    state_nxt = jtlb_utlb_resp ? ST_IDLE : ST_DRAIN;
        else if (jtlb_utlb_resp) state_nxt = ST_UPD;
      end
      ST_DRAIN: if (jtlb_utlb_resp) state_nxt = ST_IDLE;
      ST_UPD:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    complete  = 1'b0;
    upd_ok    = 1'b0;
    wr_huge   = 1'b0;
    wr_normal = 1'b0;
    merge     = 1'b0;

    utlb_jtlb_req     = 1'b0;
    utlb_jtlb_vpn     = '0;
    utlb_entry_upd    = '0;
    utlb_huge_upd     = 1'b0;
    utlb_upd_vpn      = '0;
    utlb_upd_ppn      = '0;
    utlb_upd_flg      = '0;
    utlb_refill_done0 = 1'b0;
    utlb_refill_done1 = 1'b0;
    utlb_refill_fault = 1'b0;
    utlb_refill_busy  = (state != ST_IDLE);

    case (state)
      ST_REQ: begin
        utlb_jtlb_req = 1'b1;
        utlb_jtlb_vpn = vpn_q;
        complete      = tlboper_utlb_clr;
      end
      ST_WAIT:  complete = tlboper_utlb_clr & jtlb_utlb_resp;
      ST_DRAIN: complete = jtlb_utlb_resp;
      ST_UPD: begin
        complete          = 1'b1;
        upd_ok            = ~tlboper_utlb_clr & ~fault_q;
        wr_huge           = upd_ok & (pgs_q == PGS_1G);
        wr_normal         = upd_ok & (pgs_q != PGS_1G);
        utlb_refill_fault = fault_q;
        utlb_upd_vpn      = vpn_q;
        utlb_upd_ppn      = ppn_q;
        utlb_upd_flg      = flg_q;
        utlb_huge_upd     = wr_huge;
        if (wr_normal) utlb_entry_upd = ENTRY_NUM'(1) << ptr_q;
      end
      default: ;
    endcase

    // The other port waiting on the same page completes together with this one.
    if (port_q) merge = lsu_utlb_miss0 & (lsu_utlb_vpn0 == vpn_q);
    else        merge = lsu_utlb_miss1 & (lsu_utlb_vpn1 == vpn_q);

    utlb_refill_done0 = complete & (~port_q | merge);
    utlb_refill_done1 = complete & ( port_q | merge);
  end

  always_ff @(posedge utlb_clk or posedge cpurst) begin
    if (cpurst) begin
      port_q  <= 1'b0;
      vpn_q   <= '0;
      pgs_q   <= '0;
      ppn_q   <= '0;
      flg_q   <= '0;
      fault_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      if (state == ST_IDLE && gnt_valid) begin
        port_q <= gnt_port;
        vpn_q  <= gnt_port ? lsu_utlb_vpn1 : lsu_utlb_vpn0;
      end
      if (state == ST_WAIT && jtlb_utlb_resp && !tlboper_utlb_clr) begin
        pgs_q   <= jtlb_utlb_pgs;
        ppn_q   <= jtlb_utlb_ppn;
        flg_q   <= jtlb_utlb_flg;
        fault_q <= jtlb_utlb_fault;
      end
      if (wr_normal) ptr_q <= ptr_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_mmu_dutlb_refill_ctrl.sv
// Scoreboard bench for the data uTLB refill controller: directed cases followed
// by randomized rounds, checked against a transaction-level reference model.
module tb_ct_mmu_dutlb_refill_ctrl;
  import ct_mmu_utlb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]           miss = '0;
  logic [VPN_WIDTH-1:0] vpn_in [2];
  logic                 jtlb_req;
  logic [VPN_WIDTH-1:0] jtlb_vpn;
  logic                 grnt = 1'b0, resp = 1'b0, rfault = 1'b0, clr = 1'b0;
  logic [PGS_WIDTH-1:0] rpgs = '0;
  logic [PPN_WIDTH-1:0] rppn = '0;
  logic [FLG_WIDTH-1:0] rflg = '0;
  logic [ENTRY_NUM-1:0] entry_upd;
  logic                 huge_upd, done0, done1, rf_fault, busy;
  logic [VPN_WIDTH-1:0] upd_vpn;
  logic [PPN_WIDTH-1:0] upd_ppn;
  logic [FLG_WIDTH-1:0] upd_flg;

  ct_mmu_dutlb_refill_ctrl dut (
    .utlb_clk          (clk),
    .cpurst            (rst),
    .lsu_utlb_miss0    (miss[0]),
    .lsu_utlb_miss1    (miss[1]),
    .lsu_utlb_vpn0     (vpn_in[0]),
    .lsu_utlb_vpn1     (vpn_in[1]),
    .utlb_jtlb_req     (jtlb_req),
    .utlb_jtlb_vpn     (jtlb_vpn),
    .jtlb_utlb_grnt    (grnt),
    .jtlb_utlb_resp    (resp),
    .jtlb_utlb_fault   (rfault),
    .jtlb_utlb_pgs     (rpgs),
    .jtlb_utlb_ppn     (rppn),
    .jtlb_utlb_flg     (rflg),
    .tlboper_utlb_clr  (clr),
    .utlb_entry_upd    (entry_upd),
    .utlb_huge_upd     (huge_upd),
    .utlb_upd_vpn      (upd_vpn),
    .utlb_upd_ppn      (upd_ppn),
    .utlb_upd_flg      (upd_flg),
    .utlb_refill_done0 (done0),
    .utlb_refill_done1 (done1),
    .utlb_refill_fault (rf_fault),
    .utlb_refill_busy  (busy)
  );

  typedef struct {
    logic                 d0, d1, fault, huge;
    logic [ENTRY_NUM-1:0] entry;
    logic [VPN_WIDTH-1:0] vpn;
    logic [PPN_WIDTH-1:0] ppn;
    logic [FLG_WIDTH-1:0] flg;
  } exp_done_t;

  exp_done_t            done_q[$];
  logic [VPN_WIDTH-1:0] req_q[$];

  int total = 0, passed = 0;
  int cyc = 0, last_done_cyc = 0;
  int done_cnt [2] = '{0, 0};
  int seen     [2] = '{0, 0};
  int model_ptr = 0, model_last = 1;
  bit aborted = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares every req rising edge and every completion against the queues.
  logic req_prev = 1'b0;
  always @(negedge clk) begin : mon
    logic [VPN_WIDTH-1:0] v;
    exp_done_t            e;
    if (jtlb_req && !req_prev) begin
      if (req_q.size() == 0) check("unexpected_req", 1, 0);
      else begin
        v = req_q.pop_front();
        check("req_vpn", 64'(jtlb_vpn), 64'(v));
      end
    end
    req_prev = jtlb_req;
    if (done0 || done1) begin
      last_done_cyc = cyc;
      if (done0) done_cnt[0]++;
      if (done1) done_cnt[1]++;
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = done_q.pop_front();
        check("done0", 64'(done0), 64'(e.d0));
        check("done1", 64'(done1), 64'(e.d1));
        check("fault", 64'(rf_fault), 64'(e.fault));
        check("entry_upd", 64'(entry_upd), 64'(e.entry));
        check("huge_upd", 64'(huge_upd), 64'(e.huge));
        if (e.entry != 0 || e.huge) begin
          check("upd_vpn", 64'(upd_vpn), 64'(e.vpn));
          check("upd_ppn", 64'(upd_ppn), 64'(e.ppn));
          check("upd_flg", 64'(upd_flg), 64'(e.flg));
        end
      end
    end else if (entry_upd != 0 || huge_upd) begin
      check("stray_update", 1, 0);
    end
  end

  // LSU behaviour: wait for the served port's done, then drop every completed miss.
  task automatic settle(input int port);
    int n = 0;
    while (done_cnt[port] == seen[port] && n < 8) begin
      tick();
      n++;
    end
    if (done_cnt[port] == seen[port]) begin
      check("done_timeout", 0, 1);
      aborted = 1;
    end
    for (int p = 0; p < 2; p++) begin
      if (done_cnt[p] != seen[p]) begin
        miss[p] = 1'b0;
        seen[p] = done_cnt[p];
      end
    end
  endtask

  // One jTLB transaction. mode: 0-2 normal, 3 clr in REQ, 4 clr in WAIT, 5 clr with resp.
  task automatic run_txn(input int port, input bit merged, input int mode, input int gdly,
                         input int rdly, input logic [PGS_WIDTH-1:0] pgs, input bit flt,
                         input logic [PPN_WIDTH-1:0] ppn);
    exp_done_t e;
    int n = 0;
    req_q.push_back(vpn_in[port]);
    while (!jtlb_req && n < 10) begin
      tick();
      n++;
    end
    if (!jtlb_req) begin
      check("req_timeout", 0, 1);
      aborted = 1;
      return;
    end
    model_last = port;
    e.d0 = (port == 0) || merged;
    e.d1 = (port == 1) || merged;
    e.fault = 1'b0; e.huge = 1'b0; e.entry = '0;
    e.vpn = vpn_in[port]; e.ppn = ppn; e.flg = FLG_WIDTH'($urandom);
    repeat (gdly) tick();
    rppn = ppn; rflg = e.flg; rpgs = pgs; rfault = flt;
    if (mode == 3) begin
      clr = 1'b1; done_q.push_back(e);
      tick();
      clr = 1'b0;
      check("req_drop_after_clr", 64'(jtlb_req), 0);
    end else begin
      grnt = 1'b1;
      tick();
      grnt = 1'b0;
      repeat (rdly) tick();
      if (mode == 4) begin
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (rdly) tick();
        resp = 1'b1; done_q.push_back(e);
        tick();
        resp = 1'b0;
      end else if (mode == 5) begin
        clr = 1'b1; resp = 1'b1; done_q.push_back(e);
        tick();
        clr = 1'b0; resp = 1'b0;
      end else begin
        if (flt) e.fault = 1'b1;
        else if (pgs == PGS_1G) e.huge = 1'b1;
        else begin
          e.entry = ENTRY_NUM'(1) << model_ptr;
          model_ptr = (model_ptr + 1) % ENTRY_NUM;
        end
        resp = 1'b1; done_q.push_back(e);
        tick();
        resp = 1'b0;
      end
    end
    settle(port);
  endtask

  // kind: 0 port0 only, 1 port1 only, 2 both ports.
  task automatic run_round(input int kind, input logic [VPN_WIDTH-1:0] v0,
                           input logic [VPN_WIDTH-1:0] v1, input int mode, input int gdly,
                           input int rdly, input logic [PGS_WIDTH-1:0] pgs, input bit flt,
                           input logic [PPN_WIDTH-1:0] ppn);
    int first;
    bit same;
    vpn_in[0] = v0; vpn_in[1] = v1;
    miss[0] = (kind != 1);
    miss[1] = (kind != 0);
    first = (kind == 2) ? 1 - model_last : kind;
    same = (kind == 2) && (v0 == v1);
    run_txn(first, same, mode, gdly, rdly, pgs, flt, ppn);
    if (kind == 2 && !same && !aborted)
      run_txn(1 - first, 1'b0, mode, gdly, rdly, pgs, flt, PPN_WIDTH'($urandom));
  endtask

  function automatic logic [PGS_WIDTH-1:0] rand_pgs();
    case ($urandom_range(0, 2))
      0:       return PGS_4K;
      1:       return PGS_2M;
      default: return PGS_1G;
    endcase
  endfunction

  initial begin
    int t0;
    vpn_in[0] = '0; vpn_in[1] = '0;
    repeat (3) tick();
    check("rst_req", 64'(jtlb_req), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'({done0, done1, rf_fault, huge_upd}), 0);
    check("rst_entry", 64'(entry_upd), 0);
    rst = 1'b0;
    tick();

    // First refill: minimum latency and entry 0.
    t0 = cyc;
    run_round(0, 27'h0012345, '0, 0, 0, 0, PGS_4K, 1'b0, 28'h00ABCDE);
    check("min_latency", 64'(last_done_cyc - t0), 3);
    // Eight more normal refills: the ninth wraps to entry 0.
    for (int i = 0; i < 8 && !aborted; i++)
      run_round(0, VPN_WIDTH'($urandom), '0, 0, 0, 0, PGS_4K, 1'b0, PPN_WIDTH'($urandom));
    // Back-to-back double misses alternate between ports.
    for (int i = 0; i < 4 && !aborted; i++)
      run_round(2, VPN_WIDTH'(27'h100 + i), VPN_WIDTH'(27'h200 + i), 1, 0, 1, PGS_2M, 1'b0,
                PPN_WIDTH'($urandom));
    if (!aborted) run_round(2, 27'h0777777, 27'h0777777, 0, 1, 0, PGS_4K, 1'b0, 28'h1234567);
    if (!aborted) run_round(1, '0, 27'h0ABCDEF, 0, 0, 0, PGS_1G, 1'b0, 28'h0FEDCBA);
    if (!aborted) run_round(0, 27'h0055555, '0, 0, 0, 0, PGS_4K, 1'b1, 28'h0000001);
    if (!aborted) run_round(2, 27'h0066666, 27'h0066666, 0, 0, 2, PGS_2M, 1'b1, 28'h0000002);
    if (!aborted) run_round(0, 27'h0011111, '0, 3, 1, 0, PGS_4K, 1'b0, 28'h0000003);
    if (!aborted) run_round(1, '0, 27'h0022222, 4, 0, 2, PGS_4K, 1'b0, 28'h0000004);
    if (!aborted) run_round(0, 27'h0033333, '0, 5, 0, 1, PGS_4K, 1'b0, 28'h0000005);

    for (int r = 0; r < 40 && !aborted; r++) begin
      logic [VPN_WIDTH-1:0] a, b;
      a = VPN_WIDTH'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : VPN_WIDTH'($urandom);
      run_round($urandom_range(0, 2), a, b, $urandom_range(0, 5), $urandom_range(0, 2),
                $urandom_range(0, 2), rand_pgs(), $urandom_range(0, 5) == 0,
                PPN_WIDTH'($urandom));
    end

    // Reset while waiting for a response: no done, everything back to idle.
    if (!aborted) begin
      int n = 0;
      vpn_in[0] = 27'h0424242;
      miss[0] = 1'b1;
      req_q.push_back(vpn_in[0]);
      while (!jtlb_req && n < 10) begin
        tick();
        n++;
      end
      grnt = 1'b1;
      tick();
      grnt = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 0);
      check("midrst_req", 64'(jtlb_req), 0);
      check("midrst_outs", 64'({done0, done1, rf_fault, huge_upd, entry_upd}), 0);
      tick();
      tick();
      rst = 1'b0;
      model_ptr = 0;
      model_last = 1;
      run_txn(0, 1'b0, 0, 0, 0, PGS_4K, 1'b0, 28'h0BEEF00);
    end

    repeat (3) tick();
    check("req_queue_empty", 64'(req_q.size()), 0);
    check("done_queue_empty", 64'(done_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
